// File: rtl/regfile_trace_pkg.sv
// Shared types and defaults for the register-file trace shadow.
//   dump_state_e : snapshot streamer state encoding
//   *_DEF        : default parameter values for the top and streamer
//   COMMIT_CNT_W : width of the free-running commit counter
package regfile_trace_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    STREAM  = 2'd2,
    DONE    = 2'd3
  } dump_state_e;

  localparam int REG_NUM_WIDTH_DEF  = 5;
  localparam int REG_NUM_DEF        = 32;
  localparam int REG_DATA_WIDTH_DEF = 32;
  localparam int COMMIT_CH_DEF      = 2;
  localparam int ZERO_REG_EN_DEF    = 1;
  localparam int COMMIT_CNT_W       = 64;

endpackage

// File: rtl/regfile_dump_streamer.sv
// Snapshot streamer: sequences capture and the valid/ready beat stream.
// Ports:
//   clock, reset        system clock, async active-high reset
//   dump_req            single-cycle snapshot request (ignored unless IDLE)
//   dump_ready          consumer accepts the current beat
//   snap_rd_data        snapshot word at index dump_addr (from the top)
//   capture             high during the CAPTURE cycle; top copies live->snapshot
//   dump_busy/valid/addr/data/last/done  stream outputs
//
// state   | meaning
// IDLE    | waiting for dump_req
// CAPTURE | one cycle: top freezes live array into snapshot, clears dirty
// STREAM  | beats 0..REG_NUM-1, advance on valid && ready
// DONE    | one-cycle dump_done pulse, then back to IDLE
module regfile_dump_streamer
  import regfile_trace_pkg::*;
#(
  parameter int REG_NUM_WIDTH  = REG_NUM_WIDTH_DEF,
  parameter int REG_NUM        = REG_NUM_DEF,
  parameter int REG_DATA_WIDTH = REG_DATA_WIDTH_DEF
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      dump_req,
  input  logic                      dump_ready,
  input  logic [REG_DATA_WIDTH-1:0] snap_rd_data,
  output logic                      capture,
  output logic                      dump_busy,
  output logic                      dump_valid,
  output logic [REG_NUM_WIDTH-1:0]  dump_addr,
  output logic [REG_DATA_WIDTH-1:0] dump_data,
  output logic                      dump_last,
  output logic                      dump_done
);

  localparam logic [REG_NUM_WIDTH-1:0] LAST_IDX = REG_NUM_WIDTH'(REG_NUM - 1);
  localparam logic [REG_NUM_WIDTH-1:0] ONE      = REG_NUM_WIDTH'(1);

  dump_state_e state;

  assign capture = (state == CAPTURE);
  // The snapshot only changes in CAPTURE, so indexing it by the registered
  // beat address gives a value that is stable for the whole beat.
  assign dump_data = snap_rd_data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      dump_busy  <= 1'b0;
      dump_valid <= 1'b0;
      dump_addr  <= '0;
      dump_last  <= 1'b0;
      dump_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          dump_done <= 1'b0;
          if (dump_req) begin
            state     <= CAPTURE;
            dump_busy <= 1'b1;
          end
        end
        CAPTURE: begin
          state      <= STREAM;
          dump_valid <= 1'b1;
          dump_addr  <= '0;
          dump_last  <= (LAST_IDX == '0);
        end
        STREAM: begin
          if (dump_ready) begin
            if (dump_last) begin
              state      <= DONE;
              dump_valid <= 1'b0;
              dump_last  <= 1'b0;
              dump_addr  <= '0;
              dump_done  <= 1'b1;
            end else begin
              dump_addr <= dump_addr + ONE;
              dump_last <= ((dump_addr + ONE) == LAST_IDX);
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          dump_done <= 1'b0;
          dump_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/regfile_trace_mc.sv
// Multi-channel architectural register-file shadow with snapshot dump.
// Ports:
//   clock, reset           system clock, async active-high reset
//   wr_en/wr_addr/wr_data  COMMIT_CH packed writeback channels, ch0 in LSBs;
//                          higher channel is younger and wins on same index
//   dump_req, dump_ready   snapshot request / stream back-pressure
//   dump_*                 snapshot stream outputs (see streamer)
//   dirty_mask             regs written since the last snapshot
//   commit_cnt             accepted writes, wrapping
module regfile_trace_mc
  import regfile_trace_pkg::*;
#(
  parameter int REG_NUM_WIDTH  = REG_NUM_WIDTH_DEF,
  parameter int REG_NUM        = REG_NUM_DEF,
  parameter int REG_DATA_WIDTH = REG_DATA_WIDTH_DEF,
  parameter int COMMIT_CH      = COMMIT_CH_DEF,
  parameter int ZERO_REG_EN    = ZERO_REG_EN_DEF
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [COMMIT_CH-1:0]                wr_en,
  input  logic [COMMIT_CH*REG_NUM_WIDTH-1:0]  wr_addr,
  input  logic [COMMIT_CH*REG_DATA_WIDTH-1:0] wr_data,
  input  logic                                dump_req,
  output logic                                dump_busy,
  output logic                                dump_valid,
  input  logic                                dump_ready,
  output logic [REG_NUM_WIDTH-1:0]            dump_addr,
  output logic [REG_DATA_WIDTH-1:0]           dump_data,
  output logic                                dump_last,
  output logic                                dump_done,
  output logic [REG_NUM-1:0]                  dirty_mask,
  output logic [COMMIT_CNT_W-1:0]             commit_cnt
);

  logic [REG_DATA_WIDTH-1:0] live_regs [REG_NUM];
  logic [REG_DATA_WIDTH-1:0] snap_regs [REG_NUM];
  logic [REG_DATA_WIDTH-1:0] live_next [REG_NUM];
  logic [REG_NUM-1:0]        wr_hit;
  logic [COMMIT_CNT_W-1:0]   commit_inc;
  logic [REG_DATA_WIDTH-1:0] snap_rd_data;
  logic                      capture;

  // Merge channels oldest to youngest so the highest channel overrides.
  // Out-of-range indices are neither stored nor counted; writes to a
  // hardwired r0 are counted but leave no trace in the array or dirty mask.
  always_comb begin
    commit_inc = '0;
    wr_hit     = '0;
    for (int r = 0; r < REG_NUM; r++) live_next[r] = live_regs[r];
    for (int ch = 0; ch < COMMIT_CH; ch++) begin
      if (wr_en[ch] && (int'(wr_addr[ch*REG_NUM_WIDTH +: REG_NUM_WIDTH]) < REG_NUM)) begin
        commit_inc = commit_inc + COMMIT_CNT_W'(1);
        if (!((ZERO_REG_EN != 0) && (wr_addr[ch*REG_NUM_WIDTH +: REG_NUM_WIDTH] == '0))) begin
          live_next[wr_addr[ch*REG_NUM_WIDTH +: REG_NUM_WIDTH]] =
            wr_data[ch*REG_DATA_WIDTH +: REG_DATA_WIDTH];
          wr_hit[wr_addr[ch*REG_NUM_WIDTH +: REG_NUM_WIDTH]] = 1'b1;
        end
      end
    end
  end

  // Capture takes live_next so writes retiring on the capture edge land in
  // the snapshot and therefore do not leave their dirty bits set.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < REG_NUM; r++) begin
        live_regs[r] <= '0;
        snap_regs[r] <= '0;
      end
      dirty_mask <= '0;
      commit_cnt <= '0;
    end else begin
      for (int r = 0; r < REG_NUM; r++) live_regs[r] <= live_next[r];
      if (capture) begin
        for (int r = 0; r < REG_NUM; r++) snap_regs[r] <= live_next[r];
        dirty_mask <= '0;
      end else begin
        dirty_mask <= dirty_mask | wr_hit;
      end
      commit_cnt <= commit_cnt + commit_inc;
    end
  end

  assign snap_rd_data = snap_regs[dump_addr];

  regfile_dump_streamer #(
    .REG_NUM_WIDTH (REG_NUM_WIDTH),
    .REG_NUM       (REG_NUM),
    .REG_DATA_WIDTH(REG_DATA_WIDTH)
  ) u_streamer (
    .clock       (clock),
    .reset       (reset),
    .dump_req    (dump_req),
    .dump_ready  (dump_ready),
    .snap_rd_data(snap_rd_data),
    .capture     (capture),
    .dump_busy   (dump_busy),
    .dump_valid  (dump_valid),
    .dump_addr   (dump_addr),
    .dump_data   (dump_data),
    .dump_last   (dump_last),
    .dump_done   (dump_done)
  );

endmodule

// File: tb/tb_regfile_trace_mc.sv
module tb_regfile_trace_mc;

  localparam int RW = 5;
  localparam int RN = 32;
  localparam int DW = 32;
  localparam int CH = 2;

  typedef struct packed {
    logic [RW-1:0] a;
    logic [DW-1:0] d;
  } beat_t;

  logic             clock = 1'b0;
  logic             reset;
  logic [CH-1:0]    wr_en;
  logic [CH*RW-1:0] wr_addr;
  logic [CH*DW-1:0] wr_data;
  logic             dump_req;
  logic             dump_busy;
  logic             dump_valid;
  logic             dump_ready;
  logic [RW-1:0]    dump_addr;
  logic [DW-1:0]    dump_data;
  logic             dump_last;
  logic             dump_done;
  logic [RN-1:0]    dirty_mask;
  logic [63:0]      commit_cnt;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] m_live [RN];
  logic [RN-1:0] m_dirty;
  logic [63:0]   m_cnt;
  beat_t         sb[$];

  regfile_trace_mc dut (
    .clock     (clock),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .dump_req  (dump_req),
    .dump_busy (dump_busy),
    .dump_valid(dump_valid),
    .dump_ready(dump_ready),
    .dump_addr (dump_addr),
    .dump_data (dump_data),
    .dump_last (dump_last),
    .dump_done (dump_done),
    .dirty_mask(dirty_mask),
    .commit_cnt(commit_cnt)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int r = 0; r < RN; r++) m_live[r] = '0;
    m_dirty = '0;
    m_cnt   = '0;
    sb.delete();
  endtask

  // One clock: drive at negedge, update model, return at next negedge.
  task automatic cycle(input logic [CH-1:0] en, input logic [CH*RW-1:0] a,
                       input logic [CH*DW-1:0] d, input logic req, input logic cap);
    int ai;
    wr_en = en; wr_addr = a; wr_data = d; dump_req = req;
    for (int ch = 0; ch < CH; ch++) begin
      if (en[ch]) begin
        ai = int'(a[ch*RW +: RW]);
        if (ai < RN) begin
          m_cnt = m_cnt + 64'd1;
          if (ai != 0) begin
            m_live[ai]  = d[ch*DW +: DW];
            m_dirty[ai] = 1'b1;
          end
        end
      end
    end
    if (cap) begin
      for (int r = 0; r < RN; r++) sb.push_back({RW'(r), m_live[r]});
      m_dirty = '0;
    end
    @(posedge clock);
    @(negedge clock);
    wr_en = '0; dump_req = 1'b0;
  endtask

  task automatic run_stream(input bit toggle, input int wr_trig, input logic [RW-1:0] wr_reg,
                            input logic [DW-1:0] wr_val, input int rst_trig);
    bit            finished = 0;
    bit            held = 0;
    bit            wr_done = 0;
    beat_t         held_b;
    logic          held_last;
    beat_t         exp_b;
    int            nbeats = 0;
    logic [CH-1:0] en;
    for (int g = 0; g < 400 && !finished; g++) begin
      if (held) begin
        checks++;
        if ({dump_valid, dump_addr, dump_data, dump_last} !== {1'b1, held_b.a, held_b.d, held_last}) begin
          errors++;
          $display("FAIL stall_stable: got v=%b a=%0d d=%h l=%b want v=1 a=%0d d=%h l=%b",
                   dump_valid, dump_addr, dump_data, dump_last, held_b.a, held_b.d, held_last);
        end
      end
      if (rst_trig >= 0 && dump_valid && int'(dump_addr) == rst_trig) begin
        reset = 1'b1;
        #1;
        checks++;
        if (dump_valid !== 1'b0 || dump_busy !== 1'b0) begin
          errors++;
          $display("FAIL async_abort: got valid=%b busy=%b want 0 0", dump_valid, dump_busy);
        end
        model_reset();
        return;
      end
      dump_ready = toggle ? (g % 2 == 0) : 1'b1;
      en = '0;
      if (wr_trig >= 0 && !wr_done && dump_valid && int'(dump_addr) == wr_trig) begin
        en = 2'b01;
        wr_done = 1;
      end
      if (dump_valid && dump_ready) begin
        nbeats++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL beat_extra: got beat a=%0d with empty scoreboard want none", dump_addr);
          finished = 1;
        end else begin
          exp_b = sb.pop_front();
          if ({dump_addr, dump_data, dump_last} !== {exp_b.a, exp_b.d, exp_b.a == RW'(RN - 1)}) begin
            errors++;
            $display("FAIL beat: got a=%0d d=%h l=%b want a=%0d d=%h l=%b",
                     dump_addr, dump_data, dump_last, exp_b.a, exp_b.d, exp_b.a == RW'(RN - 1));
          end
          if (exp_b.a == RW'(RN - 1)) finished = 1;
        end
      end
      held = dump_valid && !dump_ready;
      held_b = {dump_addr, dump_data};
      held_last = dump_last;
      cycle(en, {RW'(0), wr_reg}, {DW'(0), wr_val}, 1'b0, 1'b0);
    end
    dump_ready = 1'b0;
    checks++;
    if (!finished || nbeats != RN) begin
      errors++;
      $display("FAIL stream_len: got %0d beats finished=%0d want %0d beats", nbeats, finished, RN);
      return;
    end
    checks++;
    if ({dump_done, dump_busy, dump_valid} !== 3'b110) begin
      errors++;
      $display("FAIL done_pulse: got done=%b busy=%b valid=%b want 1 1 0", dump_done, dump_busy, dump_valid);
    end
    cycle('0, '0, '0, 1'b0, 1'b0);
    checks++;
    if ({dump_done, dump_busy} !== 2'b00) begin
      errors++;
      $display("FAIL done_end: got done=%b busy=%b want 0 0", dump_done, dump_busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_en = '0; wr_addr = '0; wr_data = '0; dump_req = 1'b0; dump_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    checks++;
    if ({dump_busy, dump_valid, dump_last, dump_done, dump_addr, dump_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got b=%b v=%b l=%b d=%b a=%0d data=%h want all 0",
               dump_busy, dump_valid, dump_last, dump_done, dump_addr, dump_data);
    end
    checks++;
    if (dirty_mask !== '0 || commit_cnt !== '0) begin
      errors++;
      $display("FAIL reset_state: got dirty=%h cnt=%0d want 0 0", dirty_mask, commit_cnt);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_single_write();
    cycle(2'b01, {5'd0, 5'd5}, {32'h0, 32'hDEADBEEF}, 1'b0, 1'b0);
    checks++;
    if (dut.live_regs[5] !== m_live[5] || m_live[5] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_write: got r5=%h want %h", dut.live_regs[5], 32'hDEADBEEF);
    end
    checks++;
    if (dirty_mask !== m_dirty || commit_cnt !== m_cnt) begin
      errors++;
      $display("FAIL single_state: got dirty=%h cnt=%0d want %h %0d", dirty_mask, commit_cnt, m_dirty, m_cnt);
    end
  endtask

  task automatic test_same_index();
    cycle(2'b11, {5'd3, 5'd3}, {32'h22, 32'h11}, 1'b0, 1'b0);
    checks++;
    if (dut.live_regs[3] !== m_live[3]) begin
      errors++;
      $display("FAIL same_index: got r3=%h want %h", dut.live_regs[3], m_live[3]);
    end
    cycle(2'b11, {5'd0, 5'd4}, {32'h77, 32'h44}, 1'b0, 1'b0);
    checks++;
    if (dut.live_regs[0] !== 32'h0 || dut.live_regs[4] !== m_live[4]) begin
      errors++;
      $display("FAIL zero_reg: got r0=%h r4=%h want 0 %h", dut.live_regs[0], dut.live_regs[4], m_live[4]);
    end
    checks++;
    if (dirty_mask !== m_dirty || commit_cnt !== m_cnt) begin
      errors++;
      $display("FAIL zero_state: got dirty=%h cnt=%0d want %h %0d", dirty_mask, commit_cnt, m_dirty, m_cnt);
    end
  endtask

  task automatic test_dump_full();
    cycle('0, '0, '0, 1'b1, 1'b0);
    cycle('0, '0, '0, 1'b0, 1'b1);
    checks++;
    if ({dump_busy, dump_valid} !== 2'b11 || dirty_mask !== m_dirty) begin
      errors++;
      $display("FAIL capture: got busy=%b valid=%b dirty=%h want 1 1 %h", dump_busy, dump_valid, dirty_mask, m_dirty);
    end
    run_stream(1'b0, -1, '0, '0, -1);
  endtask

  task automatic test_stall_midwrite();
    cycle(2'b01, {5'd0, 5'd7}, {32'h0, 32'h33}, 1'b0, 1'b0);
    cycle('0, '0, '0, 1'b1, 1'b0);
    cycle('0, '0, '0, 1'b0, 1'b1);
    run_stream(1'b1, 3, 5'd7, 32'h55, -1);
    checks++;
    if (dirty_mask !== m_dirty || m_dirty[7] !== 1'b1 || dut.live_regs[7] !== 32'h55) begin
      errors++;
      $display("FAIL stall_dirty: got dirty=%h r7=%h want %h %h", dirty_mask, dut.live_regs[7], m_dirty, 32'h55);
    end
  endtask

  task automatic test_capture_write();
    cycle('0, '0, '0, 1'b1, 1'b0);
    cycle(2'b01, {5'd0, 5'd9}, {32'h0, 32'hAB}, 1'b0, 1'b1);
    checks++;
    if (dirty_mask !== m_dirty || dirty_mask[9] !== 1'b0) begin
      errors++;
      $display("FAIL capture_dirty: got dirty=%h want %h", dirty_mask, m_dirty);
    end
    run_stream(1'b0, -1, '0, '0, -1);
    checks++;
    if (commit_cnt !== m_cnt) begin
      errors++;
      $display("FAIL capture_cnt: got %0d want %0d", commit_cnt, m_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int nz;
    cycle(2'b11, {5'd12, 5'd11}, {32'hC0DE, 32'hBEEF}, 1'b0, 1'b0);
    cycle('0, '0, '0, 1'b1, 1'b0);
    cycle('0, '0, '0, 1'b0, 1'b1);
    run_stream(1'b0, -1, '0, '0, 10);
    @(posedge clock);
    #1;
    checks++;
    if ({dump_done, dump_valid, dump_busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_hold: got done=%b valid=%b busy=%b want 0 0 0", dump_done, dump_valid, dump_busy);
    end
    @(negedge clock);
    reset = 1'b0;
    dump_ready = 1'b1;
    repeat (3) begin
      cycle('0, '0, '0, 1'b0, 1'b0);
      checks++;
      if ({dump_done, dump_valid, dump_busy} !== 3'b000) begin
        errors++;
        $display("FAIL reset_nodone: got done=%b valid=%b busy=%b want 0 0 0", dump_done, dump_valid, dump_busy);
      end
    end
    dump_ready = 1'b0;
    nz = 0;
    for (int r = 0; r < RN; r++) if (dut.live_regs[r] !== m_live[r]) nz++;
    checks++;
    if (nz != 0 || commit_cnt !== m_cnt || dirty_mask !== m_dirty) begin
      errors++;
      $display("FAIL reset_array: got %0d nonzero regs cnt=%0d dirty=%h want 0 0 0", nz, commit_cnt, dirty_mask);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_same_index();
    test_dump_full();
    test_stall_midwrite();
    test_capture_write();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
